// File: rtl/reloj_pkg.sv
// Shared definitions for the clock project: alarm controller state encoding
// and default timing constants.
package reloj_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } estado_alarma_t;

    localparam int SNOOZE_SEC_DEF   = 300;
    localparam int RING_MAX_SEC_DEF = 60;
    localparam int MAX_SNOOZES_DEF  = 3;

endpackage

// File: rtl/detector_flanco.sv
// Single-bit rising-edge detector: one registered copy of the input and a
// registered one-clk edge pulse.
module detector_flanco #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic flanco_o
);

    logic d_q;
    logic flanco_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q      <= RST_VAL;
            flanco_q <= 1'b0;
        end else begin
            d_q      <= d_i;
            flanco_q <= d_i & ~d_q;
        end
    end

    assign flanco_o = flanco_q;

endmodule

// File: rtl/control_alarma.sv
// Alarm controller: rings on a time match, supports a bounded number of
// snoozes, auto-silences after a maximum ring time.
module control_alarma
    import reloj_pkg::*;
#(
    parameter int SNOOZE_SEC   = SNOOZE_SEC_DEF,
    parameter int RING_MAX_SEC = RING_MAX_SEC_DEF,
    parameter int MAX_SNOOZES  = MAX_SNOOZES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick_1hz,
    input  logic           enc,
    input  logic           alarm_en,
    input  logic           btn_snooze,
    input  logic           btn_stop,
    output logic           buzzer,
    output logic           sonando,
    output logic           pospuesto,
    output logic [1:0]     n_pospuestos,
    output estado_alarma_t estado_dbg
);

    localparam int RW = (RING_MAX_SEC > 1) ? $clog2(RING_MAX_SEC) : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX_SEC - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);
    localparam logic [1:0]    MAX_N     = 2'(MAX_SNOOZES);

    logic enc_edge, snz_edge, stop_edge;

    // enc register resets high so a match still active after reset cannot ring.
    detector_flanco #(.RST_VAL(1'b1)) u_det_enc (
        .clk(clk), .rst_n(rst_n), .d_i(enc), .flanco_o(enc_edge)
    );
    detector_flanco #(.RST_VAL(1'b0)) u_det_snz (
        .clk(clk), .rst_n(rst_n), .d_i(btn_snooze), .flanco_o(snz_edge)
    );
    detector_flanco #(.RST_VAL(1'b0)) u_det_stop (
        .clk(clk), .rst_n(rst_n), .d_i(btn_stop), .flanco_o(stop_edge)
    );

    estado_alarma_t  estado_q;
    logic [RW-1:0]   ring_cnt_q;
    logic [SW-1:0]   snz_cnt_q;
    logic            buzzer_q, sonando_q, pospuesto_q;
    logic [1:0]      n_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q    <= IDLE;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            buzzer_q    <= 1'b0;
            sonando_q   <= 1'b0;
            pospuesto_q <= 1'b0;
            n_q         <= 2'd0;
        end else if (!alarm_en) begin
            estado_q    <= IDLE;
            buzzer_q    <= 1'b0;
            sonando_q   <= 1'b0;
            pospuesto_q <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (enc_edge) begin
                        estado_q   <= RING;
                        n_q        <= 2'd0;
                        ring_cnt_q <= '0;
                        buzzer_q   <= 1'b1;
                        sonando_q  <= 1'b1;
                    end
                end
                RING: begin
                    if (stop_edge) begin
                        estado_q  <= IDLE;
                        buzzer_q  <= 1'b0;
                        sonando_q <= 1'b0;
                    end else if (snz_edge && (n_q < MAX_N)) begin
                        estado_q    <= SNOOZE;
                        n_q         <= n_q + 2'd1;
                        snz_cnt_q   <= '0;
                        buzzer_q    <= 1'b0;
                        sonando_q   <= 1'b0;
                        pospuesto_q <= 1'b1;
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RING_LAST) begin
                            estado_q  <= IDLE;
                            buzzer_q  <= 1'b0;
                            sonando_q <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + 1'b1;
                            buzzer_q   <= ~buzzer_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_edge) begin
                        estado_q    <= IDLE;
                        pospuesto_q <= 1'b0;
                    end else if (tick_1hz) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            estado_q    <= RING;
                            ring_cnt_q  <= '0;
                            buzzer_q    <= 1'b1;
                            sonando_q   <= 1'b1;
                            pospuesto_q <= 1'b0;
                        end else begin
                            snz_cnt_q <= snz_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    estado_q    <= IDLE;
                    buzzer_q    <= 1'b0;
                    sonando_q   <= 1'b0;
                    pospuesto_q <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer       = buzzer_q;
    assign sonando      = sonando_q;
    assign pospuesto    = pospuesto_q;
    assign n_pospuestos = n_q;
    assign estado_dbg   = estado_q;

endmodule

// File: tb/tb_control_alarma.sv
// Directed bench for control_alarma with short timing parameters
// (snooze 5 ticks, ring 4 ticks, 2 snoozes per event).
module tb_control_alarma;
    import reloj_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n, tick_1hz, enc, alarm_en, btn_snooze, btn_stop;
    logic           buzzer, sonando, pospuesto;
    logic [1:0]     n_pospuestos;
    estado_alarma_t estado_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_alarma #(
        .SNOOZE_SEC(5), .RING_MAX_SEC(4), .MAX_SNOOZES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .enc(enc),
        .alarm_en(alarm_en), .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .buzzer(buzzer), .sonando(sonando), .pospuesto(pospuesto),
        .n_pospuestos(n_pospuestos), .estado_dbg(estado_dbg)
    );

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(1);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {buzzer, sonando, pospuesto, n_pospuestos} for compact checks.
    function automatic logic [7:0] outs();
        return {3'b0, buzzer, sonando, pospuesto, n_pospuestos};
    endfunction

    initial begin
        logic never_rang;
        rst_n = 1'b0; tick_1hz = 1'b0; enc = 1'b0; alarm_en = 1'b1;
        btn_snooze = 1'b0; btn_stop = 1'b0;
        cyc(3);
        check("reset_outputs", outs(), 8'h00);
        rst_n = 1'b1;
        cyc(2);
        check("idle_after_reset", outs(), 8'h00);

        // Alarm match: two clk from input edge to ring.
        enc = 1'b1;
        cyc(1);
        check("ring_latency_1clk", outs(), 8'h00);
        cyc(1);
        check("ring_start", outs(), 8'b000_1_1_0_00);
        tick();
        check("ring_tick1_buzz_off", outs(), 8'b000_0_1_0_00);
        tick();
        check("ring_tick2_buzz_on", outs(), 8'b000_1_1_0_00);
        tick();
        check("ring_tick3_buzz_off", outs(), 8'b000_0_1_0_00);
        tick();
        check("ring_auto_silence", outs(), 8'b000_0_0_0_00);

        // New event: snooze twice, third snooze ignored, then stop.
        enc = 1'b0;
        cyc(2);
        enc = 1'b1;
        cyc(2);
        check("ring2_start", outs(), 8'b000_1_1_0_00);
        btn_snooze = 1'b1;
        cyc(2);
        check("snooze1", outs(), 8'b000_0_0_1_01);
        btn_snooze = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("snooze1_4ticks", outs(), 8'b000_0_0_1_01);
        tick();
        check("snooze1_expire_ring", outs(), 8'b000_1_1_0_01);
        btn_snooze = 1'b1;
        cyc(2);
        check("snooze2", outs(), 8'b000_0_0_1_10);
        btn_snooze = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("snooze2_expire_ring", outs(), 8'b000_1_1_0_10);
        btn_snooze = 1'b1;
        cyc(2);
        check("snooze3_ignored", outs(), 8'b000_1_1_0_10);
        cyc(3);
        check("snooze_held_no_retrigger", outs(), 8'b000_1_1_0_10);
        btn_snooze = 1'b0;
        enc = 1'b0;
        cyc(1);
        enc = 1'b1;
        cyc(2);
        check("enc_edge_in_ring_ignored", {6'b0, estado_dbg}, {6'b0, RING});
        btn_stop = 1'b1;
        cyc(2);
        check("stop_to_idle_n_held", outs(), 8'b000_0_0_0_10);
        btn_stop = 1'b0;
        cyc(3);
        check("idle_n_still_held", outs(), 8'b000_0_0_0_10);

        // Stop and snooze on the same cycle: stop wins.
        enc = 1'b0;
        cyc(2);
        enc = 1'b1;
        cyc(2);
        check("ring3_start_n_cleared", outs(), 8'b000_1_1_0_00);
        btn_stop = 1'b1; btn_snooze = 1'b1;
        cyc(2);
        check("stop_beats_snooze", outs(), 8'b000_0_0_0_00);
        btn_stop = 1'b0; btn_snooze = 1'b0;

        // Disable during snooze, then hold match with alarm disabled.
        enc = 1'b0;
        cyc(2);
        enc = 1'b1;
        cyc(2);
        btn_snooze = 1'b1;
        cyc(2);
        check("snooze4", outs(), 8'b000_0_0_1_01);
        btn_snooze = 1'b0;
        alarm_en = 1'b0;
        cyc(1);
        check("disable_forces_idle", {6'b0, estado_dbg}, {6'b0, IDLE});
        check("disable_outputs", outs(), 8'b000_0_0_0_01);
        enc = 1'b0;
        cyc(2);
        enc = 1'b1;
        never_rang = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (sonando !== 1'b0 || buzzer !== 1'b0) never_rang = 1'b0;
        end
        check("disabled_no_ring_60_ticks", {7'b0, never_rang}, 8'h01);
        alarm_en = 1'b1;
        cyc(3);
        check("enable_with_enc_held_no_ring", outs(), 8'b000_0_0_0_01);

        // Reset during ring with match still high.
        enc = 1'b0;
        cyc(2);
        enc = 1'b1;
        cyc(2);
        check("ring5_start", outs(), 8'b000_1_1_0_00);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("reset_mid_ring", outs(), 8'h00);
        cyc(4);
        check("no_retrigger_after_reset", outs(), 8'h00);
        enc = 1'b0;
        cyc(2);
        enc = 1'b1;
        cyc(2);
        check("ring_after_new_edge", outs(), 8'b000_1_1_0_00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
